// File: rtl/maskvect_pkg.sv
// Shared constants, FSM state type and priority encoder for the mask-vector engine.
package maskvect_pkg;
  localparam int unsigned NSEG    = 13;
  localparam int unsigned IDWID   = 8;
  localparam int unsigned SEGWID  = IDWID + 2;
  localparam int unsigned LWID    = $clog2(NSEG);
  localparam int unsigned DEPTH   = 2 ** IDWID;
  localparam int unsigned CW      = IDWID + 1;
  localparam int unsigned SEG_VLD = IDWID;
  localparam int unsigned SEG_WC  = IDWID + 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [LWID-1:0] lsb_index(input logic [NSEG-1:0] v);
    logic [LWID-1:0] idx;
    idx = '0;
    for (int i = NSEG - 1; i >= 0; i--) begin
      if (v[i]) idx = LWID'(i);
    end
    return idx;
  endfunction
endpackage

// File: rtl/maskvect_array_if.sv
// Search, write, clear and result signals of the mask-vector engine.
interface maskvect_array_if;
  import maskvect_pkg::*;

  logic                   i_Search_Valid;
  logic                   o_Search_Ready;
  logic [SEGWID*NSEG-1:0] i_Segment_Vector;
  logic                   i_Wr_En;
  logic                   o_Wr_Ready;
  logic [LWID-1:0]        i_Wr_Lane;
  logic [IDWID-1:0]       i_Wr_Addr;
  logic [NSEG-1:0]        i_Wr_Data;
  logic                   i_Clear;
  logic                   o_Busy;
  logic                   o_Valid;
  logic [NSEG*NSEG-1:0]   o_Mask_Vector;
  logic [NSEG-1:0]        o_Match_Vect;
  logic                   o_Hit;
  logic [LWID-1:0]        o_Hit_Idx;

  modport master (
    output i_Search_Valid, i_Segment_Vector, i_Wr_En, i_Wr_Lane, i_Wr_Addr, i_Wr_Data, i_Clear,
    input  o_Search_Ready, o_Wr_Ready, o_Busy, o_Valid, o_Mask_Vector, o_Match_Vect, o_Hit, o_Hit_Idx
  );
  modport slave (
    input  i_Search_Valid, i_Segment_Vector, i_Wr_En, i_Wr_Lane, i_Wr_Addr, i_Wr_Data, i_Clear,
    output o_Search_Ready, o_Wr_Ready, o_Busy, o_Valid, o_Mask_Vector, o_Match_Vect, o_Hit, o_Hit_Idx
  );
endinterface

// File: rtl/maskvect_lane_ram.sv
// One lane of mask storage: simple dual-port RAM, synchronous read-first.
module maskvect_lane_ram
  import maskvect_pkg::*;
(
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDWID-1:0] wr_addr,
  input  logic [NSEG-1:0]  wr_data,
  input  logic             rd_en,
  input  logic [IDWID-1:0] rd_addr,
  output logic [NSEG-1:0]  rd_data
);
  logic [NSEG-1:0] mem [DEPTH];

  // No reset on storage or read register so the array maps onto a block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/maskvect_array.sv
// Segmented TCAM mask-vector engine: per-lane mask RAMs, status gating,
// AND reduction and lowest-rule priority encode behind a 2-cycle search pipe.
module maskvect_array
  import maskvect_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  maskvect_array_if.slave bus
);
  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 busy_nxt, ready_nxt;
  logic                 srch_acc, wr_acc, clr_we;
  logic [NSEG-1:0]      vld_in, wc_in, vld1, wc1, match_c;
  logic [NSEG-1:0]      rd_data [NSEG];
  logic [NSEG-1:0]      gated   [NSEG];
  logic [NSEG*NSEG-1:0] mask_c;
  logic                 v1;

  assign srch_acc = bus.i_Search_Valid & bus.o_Search_Ready;
  assign wr_acc   = bus.i_Wr_En & bus.o_Wr_Ready & (bus.i_Wr_Lane < LWID'(NSEG));
  assign clr_we   = (state == ST_CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_CLEAR;
      cnt                <= '0;
      bus.o_Busy         <= 1'b1;
      bus.o_Search_Ready <= 1'b0;
      bus.o_Wr_Ready     <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      bus.o_Busy         <= busy_nxt;
      bus.o_Search_Ready <= ready_nxt;
      bus.o_Wr_Ready     <= ready_nxt;
    end
  end

  // Clear sweep visits every address once, then returns to IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = 1'b0;
    ready_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_Clear) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt  = (state_nxt == ST_CLEAR);
    ready_nxt = (state_nxt == ST_IDLE);
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_lane
    assign vld_in[k] = bus.i_Segment_Vector[k*SEGWID + SEG_VLD];
    assign wc_in[k]  = bus.i_Segment_Vector[k*SEGWID + SEG_WC];

    maskvect_lane_ram u_ram (
      .clk     (clk),
      .wr_en   (clr_we | (wr_acc & (bus.i_Wr_Lane == LWID'(k)))),
      .wr_addr (clr_we ? cnt[IDWID-1:0] : bus.i_Wr_Addr),
      .wr_data (clr_we ? '0 : bus.i_Wr_Data),
      .rd_en   (srch_acc),
      .rd_addr (bus.i_Segment_Vector[k*SEGWID +: IDWID]),
      .rd_data (rd_data[k])
    );
  end

  // Stage 1: status bits travel alongside the RAM read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      vld1 <= '0;
      wc1  <= '0;
    end else begin
      v1 <= srch_acc;
      if (srch_acc) begin
        vld1 <= vld_in;
        wc1  <= wc_in;
      end
    end
  end

  // Invalid lanes block every rule, wildcard lanes pass every rule.
  always_comb begin
    mask_c  = '0;
    match_c = '1;
    for (int k = 0; k < NSEG; k++) begin
      gated[k] = !vld1[k] ? '0 : (wc1[k] ? '1 : rd_data[k]);
      mask_c[k*NSEG +: NSEG] = gated[k];
      match_c = match_c & gated[k];
    end
  end

  // Stage 2: results update only on a valid search and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.o_Valid       <= 1'b0;
      bus.o_Mask_Vector <= '0;
      bus.o_Match_Vect  <= '0;
      bus.o_Hit         <= 1'b0;
      bus.o_Hit_Idx     <= '0;
    end else begin
      bus.o_Valid <= v1;
      if (v1) begin
        bus.o_Mask_Vector <= mask_c;
        bus.o_Match_Vect  <= match_c;
        bus.o_Hit         <= |match_c;
        bus.o_Hit_Idx     <= lsb_index(match_c);
      end
    end
  end
endmodule

// File: tb/tb_maskvect_array.sv
// Directed self-checking bench for maskvect_array.
module tb_maskvect_array;
  import maskvect_pkg::*;

  localparam int unsigned MW = NSEG * NSEG;
  localparam int unsigned SW = SEGWID * NSEG;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  maskvect_array_if bus();

  maskvect_array dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SEGWID-1:0] mk(input logic [IDWID-1:0] id, input logic vld, input logic wc);
    return {wc, vld, id};
  endfunction

  function automatic logic [SW-1:0] all_seg(input logic [IDWID-1:0] id, input logic vld, input logic wc);
    logic [SW-1:0] v;
    v = '0;
    for (int k = 0; k < NSEG; k++) v[k*SEGWID +: SEGWID] = mk(id, vld, wc);
    return v;
  endfunction

  function automatic logic [NSEG-1:0] lane(input int k);
    return bus.o_Mask_Vector[k*NSEG +: NSEG];
  endfunction

  task automatic wr(input int ln, input logic [IDWID-1:0] addr, input logic [NSEG-1:0] data);
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Lane = LWID'(ln);
    bus.i_Wr_Addr = addr;
    bus.i_Wr_Data = data;
    tick();
    bus.i_Wr_En   = 1'b0;
  endtask

  // Single search; returns with the result expected on the outputs.
  task automatic do_search(input string tag, input logic [SW-1:0] vec);
    bus.i_Segment_Vector = vec;
    bus.i_Search_Valid   = 1'b1;
    tick();
    bus.i_Search_Valid   = 1'b0;
    chk({tag, "_lat1"}, MW'(bus.o_Valid), MW'(0));
    tick();
    chk({tag, "_valid"}, MW'(bus.o_Valid), MW'(1));
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.o_Busy) break;
      n++;
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] v;
    int n, bad, vcnt;

    bus.i_Search_Valid   = 1'b0;
    bus.i_Segment_Vector = '0;
    bus.i_Wr_En          = 1'b0;
    bus.i_Wr_Lane        = '0;
    bus.i_Wr_Addr        = '0;
    bus.i_Wr_Data        = '0;
    bus.i_Clear          = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy",   MW'(bus.o_Busy),         MW'(1));
    chk("rst_sready", MW'(bus.o_Search_Ready), MW'(0));
    chk("rst_wready", MW'(bus.o_Wr_Ready),     MW'(0));
    chk("rst_valid",  MW'(bus.o_Valid),        MW'(0));
    chk("rst_match",  MW'(bus.o_Match_Vect),   MW'(0));

    // Power-up sweep
    rst = 1'b1;
    count_busy(n);
    chk("sweep0_len",  MW'(n),                  MW'(256));
    chk("idle_sready", MW'(bus.o_Search_Ready), MW'(1));
    chk("idle_wready", MW'(bus.o_Wr_Ready),     MW'(1));

    // Cleared RAM gives no hit
    do_search("s_zero", all_seg(8'h00, 1'b1, 1'b0));
    chk("zero_match", MW'(bus.o_Match_Vect), MW'(0));
    chk("zero_hit",   MW'(bus.o_Hit),        MW'(0));
    chk("zero_idx",   MW'(bus.o_Hit_Idx),    MW'(0));
    tick();
    chk("pulse_valid", MW'(bus.o_Valid), MW'(0));

    // Same word in every lane
    for (int k = 0; k < NSEG; k++) wr(k, 8'h05, 13'h0014);
    do_search("s_basic", all_seg(8'h05, 1'b1, 1'b0));
    chk("basic_match", MW'(bus.o_Match_Vect), MW'(13'h0014));
    chk("basic_hit",   MW'(bus.o_Hit),        MW'(1));
    chk("basic_idx",   MW'(bus.o_Hit_Idx),    MW'(2));
    chk("basic_lane7", MW'(lane(7)),          MW'(13'h0014));

    // Wildcard lane
    v = all_seg(8'h05, 1'b1, 1'b0);
    v[3*SEGWID +: SEGWID] = mk(8'h77, 1'b1, 1'b1);
    do_search("s_wc", v);
    chk("wc_match", MW'(bus.o_Match_Vect), MW'(13'h0014));
    chk("wc_lane3", MW'(lane(3)),          MW'(13'h1FFF));

    // Invalid lane
    v[3*SEGWID +: SEGWID] = mk(8'h05, 1'b0, 1'b0);
    do_search("s_inv", v);
    chk("inv_lane3", MW'(lane(3)),          MW'(0));
    chk("inv_match", MW'(bus.o_Match_Vect), MW'(0));
    chk("inv_hit",   MW'(bus.o_Hit),        MW'(0));

    // Read-first collision, then the new data one cycle later
    bus.i_Segment_Vector = all_seg(8'h05, 1'b1, 1'b0);
    bus.i_Search_Valid   = 1'b1;
    bus.i_Wr_En          = 1'b1;
    bus.i_Wr_Lane        = '0;
    bus.i_Wr_Addr        = 8'h05;
    bus.i_Wr_Data        = 13'h1FFF;
    tick();
    bus.i_Wr_En          = 1'b0;
    tick();
    bus.i_Search_Valid   = 1'b0;
    chk("rf_old_valid", MW'(bus.o_Valid), MW'(1));
    chk("rf_old_lane0", MW'(lane(0)),     MW'(13'h0014));
    tick();
    chk("rf_new_valid", MW'(bus.o_Valid),      MW'(1));
    chk("rf_new_lane0", MW'(lane(0)),          MW'(13'h1FFF));
    chk("rf_new_match", MW'(bus.o_Match_Vect), MW'(13'h0014));

    // Out-of-range lane is dropped
    wr(13, 8'h06, 13'h1FFF);
    do_search("s_oob", all_seg(8'h06, 1'b1, 1'b0));
    chk("oob_mask", bus.o_Mask_Vector, MW'(0));

    // Top rule index
    for (int k = 0; k < NSEG; k++) wr(k, 8'h09, 13'h1000 | (13'h1 << k));

    // Back-to-back searches with a clear right behind them
    v = all_seg(8'h05, 1'b1, 1'b0);
    v[0*SEGWID +: SEGWID] = mk(8'h05, 1'b0, 1'b0);
    bus.i_Search_Valid   = 1'b1;
    bus.i_Segment_Vector = all_seg(8'h05, 1'b1, 1'b0);
    tick();
    bus.i_Segment_Vector = all_seg(8'h09, 1'b1, 1'b0);
    tick();
    chk("b2b0_valid", MW'(bus.o_Valid),      MW'(1));
    chk("b2b0_match", MW'(bus.o_Match_Vect), MW'(13'h0014));
    bus.i_Segment_Vector = all_seg(8'h00, 1'b1, 1'b1);
    tick();
    chk("b2b1_valid", MW'(bus.o_Valid),      MW'(1));
    chk("b2b1_match", MW'(bus.o_Match_Vect), MW'(13'h1000));
    chk("b2b1_idx",   MW'(bus.o_Hit_Idx),    MW'(12));
    bus.i_Segment_Vector = v;
    tick();
    chk("b2b2_valid", MW'(bus.o_Valid),      MW'(1));
    chk("b2b2_match", MW'(bus.o_Match_Vect), MW'(13'h1FFF));
    chk("b2b2_idx",   MW'(bus.o_Hit_Idx),    MW'(0));
    bus.i_Search_Valid = 1'b0;
    bus.i_Clear        = 1'b1;
    tick();
    bus.i_Clear        = 1'b0;
    chk("b2b3_valid", MW'(bus.o_Valid),        MW'(1));
    chk("b2b3_match", MW'(bus.o_Match_Vect),   MW'(0));
    chk("b2b3_hit",   MW'(bus.o_Hit),          MW'(0));
    chk("clr_busy",   MW'(bus.o_Busy),         MW'(1));
    chk("clr_sready", MW'(bus.o_Search_Ready), MW'(0));

    // Sweep rejects writes and searches
    bus.i_Wr_En          = 1'b1;
    bus.i_Wr_Lane        = '0;
    bus.i_Wr_Addr        = 8'h20;
    bus.i_Wr_Data        = 13'h1FFF;
    bus.i_Search_Valid   = 1'b1;
    bus.i_Segment_Vector = all_seg(8'h20, 1'b1, 1'b0);
    n = 0; bad = 0; vcnt = 0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.o_Busy) break;
      if (bus.o_Search_Ready || bus.o_Wr_Ready) bad++;
      n++;
      tick();
      if (bus.o_Valid) vcnt++;
    end
    bus.i_Wr_En        = 1'b0;
    bus.i_Search_Valid = 1'b0;
    chk("sweep1_len",   MW'(n),    MW'(256));
    chk("sweep1_ready", MW'(bad),  MW'(0));
    chk("sweep1_valid", MW'(vcnt), MW'(0));
    do_search("s_drop", all_seg(8'h20, 1'b1, 1'b0));
    chk("drop_mask", bus.o_Mask_Vector, MW'(0));
    do_search("s_clr", all_seg(8'h05, 1'b1, 1'b0));
    chk("clr_lane5",  MW'(lane(5)),          MW'(0));
    chk("clr_match",  MW'(bus.o_Match_Vect), MW'(0));

    // Reset partway through a sweep
    bus.i_Segment_Vector = all_seg(8'h00, 1'b1, 1'b1);
    bus.i_Search_Valid   = 1'b1;
    tick();
    bus.i_Search_Valid   = 1'b0;
    bus.i_Clear          = 1'b1;
    tick();
    bus.i_Clear          = 1'b0;
    chk("pre_rst_match", MW'(bus.o_Match_Vect), MW'(13'h1FFF));
    repeat (100) tick();
    chk("mid_hold_match", MW'(bus.o_Match_Vect), MW'(13'h1FFF));
    chk("mid_busy",       MW'(bus.o_Busy),       MW'(1));
    rst = 1'b0;
    #1;
    chk("mrst_match",  MW'(bus.o_Match_Vect),   MW'(0));
    chk("mrst_mask",   bus.o_Mask_Vector,       MW'(0));
    chk("mrst_hit",    MW'(bus.o_Hit),          MW'(0));
    chk("mrst_busy",   MW'(bus.o_Busy),         MW'(1));
    chk("mrst_sready", MW'(bus.o_Search_Ready), MW'(0));
    tick();
    rst = 1'b1;
    count_busy(n);
    chk("sweep2_len",    MW'(n),                  MW'(256));
    chk("sweep2_sready", MW'(bus.o_Search_Ready), MW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
